// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, 2-entry fetch queue and RUN/HALTED FSM.
// Redirects flush the queue and restart fetch; a halt word stops fetching.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] e0_pc_q, e0_pc_d;
  logic [31:0] e0_inst_q, e0_inst_d;
  logic [31:0] e1_pc_q, e1_pc_d;
  logic [31:0] e1_inst_q, e1_inst_d;
  logic [31:0] fcnt_q, fcnt_d;
  logic        pop, push;
  logic [1:0]  wr_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      count_q   <= 2'd0;
      e0_pc_q   <= 32'd0;
      e0_inst_q <= 32'd0;
      e1_pc_q   <= 32'd0;
      e1_inst_q <= 32'd0;
      fcnt_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      e0_pc_q   <= e0_pc_d;
      e0_inst_q <= e0_inst_d;
      e1_pc_q   <= e1_pc_d;
      e1_inst_q <= e1_inst_d;
      fcnt_q    <= fcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    e0_pc_d   = e0_pc_q;
    e0_inst_d = e0_inst_q;
    e1_pc_d   = e1_pc_q;
    e1_inst_d = e1_inst_q;
    fcnt_d    = fcnt_q;
    pop       = (count_q != 2'd0) && id_ready;
    push      = (state_q == RUN) && ((count_q != 2'd2) || pop);
    wr_idx    = count_q - {1'b0, pop};

    if (redirect_valid) begin
      // Wrong-path fetch this cycle: flush everything, no push or pop
      count_d = 2'd0;
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = RUN;
    end else begin
      if (pop) begin
        e0_pc_d   = e1_pc_q;
        e0_inst_d = e1_inst_q;
      end
      if (push) begin
        if (wr_idx == 2'd0) begin
          e0_pc_d   = pc_q;
          e0_inst_d = imem_dout;
        end else begin
          e1_pc_d   = pc_q;
          e1_inst_d = imem_dout;
        end
        fcnt_d = fcnt_q + 32'd1;
        if (imem_dout == HALT_INST) begin
          state_d = HALTED;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      count_d = count_q - {1'b0, pop} + {1'b0, push};
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = (count_q != 2'd0);
  assign id_inst     = e0_inst_q;
  assign id_pc       = e0_pc_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = fcnt_q;

endmodule
